mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Responder end of the CPU data/instruction memory interface.
- Accepts read/write strobes from the multicycle controller and datapath, then performs the access after a programmable number of wait states.
- Signals completion with a one-cycle `mem_ready` pulse and holds read data stable until the next read completes.
- Replaces the zero-latency memory so the controller can be exercised against realistic memory timing.

Parameters:
- DATA_W, 16, word width of storage and data ports.
- DEPTH_LOG2, 8, log2 of word count; storage holds 2^DEPTH_LOG2 words.
- WAIT_CYCLES, 1, wait-state cycles between accept and access (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_addr  input  16  word address from datapath.
- mem_wr_data  input  DATA_W  write data.
- mem_read  input  1  read strobe.
- mem_write  input  1  write strobe.
- mem_data_out  output  DATA_W  registered read data.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high whenever state != IDLE.
- mem_err  output  1  range error flag; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high, on clk edge):
  - State goes to IDLE; wait counter = 0.
  - `mem_data_out` = 0, `mem_ready` = 0, `mem_err` = 0.
  - Storage array is NOT cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - At an edge with `mem_read` or `mem_write` high: latch addr, wr_data and op; load counter with WAIT_CYCLES; go to BUSY.
  - Both strobes high: write wins, read is dropped (no read data update).
  - Neither strobe high: stay in IDLE.
- BUSY:
  - Counter != 0: decrement, stay in BUSY.
  - Counter == 0: perform the access, go to DONE, set `mem_ready` = 1.
    - Write: array[addr] <= latched data.
    - Read: `mem_data_out` <= array[addr].
  - Strobe or address changes during BUSY are ignored; latched values are used.
- DONE: `mem_ready` = 0, go to IDLE unconditionally. Strobes seen at the DONE edge are ignored; the requester must re-present them in IDLE.
- Timing, request accepted at edge N:
  - Access and `mem_ready` rise at edge N+WAIT_CYCLES+1.
  - `mem_ready` falls at edge N+WAIT_CYCLES+2.
  - Earliest next accept is edge N+WAIT_CYCLES+3.
- `mem_ready` is high for exactly one cycle per accepted request.
- `mem_data_out` holds its value across writes and idle cycles; it changes only on read completion or reset.
- Address mapping: index = `mem_addr[DEPTH_LOG2-1:0]`. Upper bits are ignored, so addresses wrap/alias unless the optional feature is enabled.
- Reset mid-operation (BUSY or DONE): a pending write is discarded (array unchanged), a pending read is discarded, and any asserted `mem_ready` drops.
- WAIT_CYCLES = 0: accept at N, access and ready at N+1.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined:
  - At access time, any set bit in `mem_addr[15:DEPTH_LOG2]` is an out-of-range access.
  - Out-of-range write: no array update.
  - Out-of-range read: `mem_data_out` <= 0.
  - `mem_err` = 1 for the same single cycle as `mem_ready`; 0 otherwise.
- Undefined: addresses alias modulo 2^DEPTH_LOG2 and `mem_err` is tied to 0.

Test Plan:
- Reset, then idle 5 cycles -> `mem_ready` = 0, `mem_busy` = 0, `mem_data_out` = 0x0000 throughout.
- WAIT_CYCLES=1: write 0x0005 <= 0xBEEF accepted at edge 0 -> `mem_busy` high edges 0..2, `mem_ready` high only cycle after edge 2; then read 0x0005 -> `mem_data_out` = 0xBEEF with `mem_ready`.
- `mem_read` and `mem_write` both high, addr 0x0007, data 0x1111 -> array[7] = 0x1111, `mem_data_out` unchanged, one ready pulse.
- Write 0x0010 <= 0xAAAA; then start write 0x0010 <= 0x1234 and assert reset during BUSY -> `mem_ready` stays 0; subsequent read 0x0010 returns 0xAAAA.
- Strobes held high and addr changed to 0x0020 while BUSY on read of 0x0005 -> data 0xBEEF returned, exactly one ready pulse, next access starts only from IDLE.
- DEPTH_LOG2=8, write 0x0103 <= 0x5555, then read 0x0003:
  - Without macro -> 0x5555, `mem_err` = 0.
  - With MEM_RANGE_CHECK_EN -> write blocked with `mem_err` pulse, read 0x0003 returns the old value, read 0x0103 returns 0x0000 with `mem_err` = 1.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: wait-stated memory responder with one-cycle ready pulse.
// Define MEM_RANGE_CHECK_EN to flag and block accesses above 2^DEPTH_LOG2 words.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  op_wr_q, op_wr_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  we;
    logic                  oor;
    logic [DATA_W-1:0]     mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    assign idx = addr_q[DEPTH_LOG2-1:0];
`ifdef MEM_RANGE_CHECK_EN
    assign oor = |addr_q[15:DEPTH_LOG2];
`else
    logic unused_hi;
    assign unused_hi = |addr_q[15:DEPTH_LOG2];
    assign oor = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        case (state_q)
            IDLE: if (mem_read || mem_write) begin
                addr_d  = mem_addr;
                wdata_d = mem_wr_data;
                op_wr_d = mem_write;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = BUSY;
            end
            BUSY: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = DONE;
                ready_d = 1'b1;
                err_d   = oor;
                we      = op_wr_q && !oor;
                rdata_d = op_wr_q ? rdata_q : (oor ? '0 : mem_q[idx]);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end
    // Request latches and storage are never cleared; reset only suppresses the write.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        op_wr_q <= op_wr_d;
        if (we && !reset) mem_q[idx] <= wdata_q;
    end
    assign mem_data_out = rdata_q;
    assign mem_ready    = ready_q;
    assign mem_busy     = state_q != IDLE;
    assign mem_err      = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder timing, data and reset behaviour.
module tb_mem_responder;
    localparam int WAIT = 1;
`ifdef MEM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wr_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_data_out;
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;
    int checks = 0;
    int errors = 0;
    mem_responder #(.DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk),
        .reset(reset),
        .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_data_out(mem_data_out),
        .mem_ready(mem_ready),
        .mem_busy(mem_busy),
        .mem_err(mem_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // One request: accept, WAIT busy cycles, ready pulse with expected data/err, then idle.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp_q, input logic exp_e);
        mem_read = rd;
        mem_write = wr;
        mem_addr = a;
        mem_wr_data = d;
        tick();
        chk({tag, ":accept_busy"}, 32'(mem_busy), 1);
        chk({tag, ":accept_ready"}, 32'(mem_ready), 0);
        mem_read = 1'b0;
        mem_write = 1'b0;
        for (int k = 1; k <= WAIT; k++) begin
            tick();
            chk({tag, ":wait_ready"}, 32'(mem_ready), 0);
            chk({tag, ":wait_busy"}, 32'(mem_busy), 1);
        end
        tick();
        chk({tag, ":ready"}, 32'(mem_ready), 1);
        chk({tag, ":done_busy"}, 32'(mem_busy), 1);
        chk({tag, ":err"}, 32'(mem_err), 32'(exp_e));
        chk({tag, ":data"}, 32'(mem_data_out), 32'(exp_q));
        tick();
        chk({tag, ":ready_fall"}, 32'(mem_ready), 0);
        chk({tag, ":idle_busy"}, 32'(mem_busy), 0);
        chk({tag, ":err_fall"}, 32'(mem_err), 0);
        chk({tag, ":data_hold"}, 32'(mem_data_out), 32'(exp_q));
    endtask
    initial begin
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ready", 32'(mem_ready), 0);
            chk("idle_busy", 32'(mem_busy), 0);
            chk("idle_data", 32'(mem_data_out), 0);
        end
        access("wr5", 1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0);
        access("rd5", 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);
        access("both7", 1'b1, 1'b1, 16'h0007, 16'h1111, 16'hBEEF, 1'b0);
        access("rd7", 1'b1, 1'b0, 16'h0007, 16'h0000, 16'h1111, 1'b0);
        access("wr10", 1'b0, 1'b1, 16'h0010, 16'hAAAA, 16'h1111, 1'b0);
        mem_write = 1'b1;
        mem_addr = 16'h0010;
        mem_wr_data = 16'h1234;
        tick();
        chk("rst_accept_busy", 32'(mem_busy), 1);
        mem_write = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_busy", 32'(mem_busy), 0);
        chk("rst_ready", 32'(mem_ready), 0);
        chk("rst_data", 32'(mem_data_out), 0);
        reset = 1'b0;
        tick();
        chk("rst_noready", 32'(mem_ready), 0);
        tick();
        chk("rst_noready2", 32'(mem_ready), 0);
        access("rd10", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hAAAA, 1'b0);
        access("wr20", 1'b0, 1'b1, 16'h0020, 16'h2020, 16'hAAAA, 1'b0);
        mem_read = 1'b1;
        mem_addr = 16'h0005;
        tick();
        chk("hold_accept", 32'(mem_busy), 1);
        mem_addr = 16'h0020;
        tick();
        chk("hold_wait_ready", 32'(mem_ready), 0);
        tick();
        chk("hold_ready", 32'(mem_ready), 1);
        chk("hold_data", 32'(mem_data_out), 32'hBEEF);
        tick();
        chk("hold_done_ready", 32'(mem_ready), 0);
        chk("hold_done_busy", 32'(mem_busy), 0);
        tick();
        chk("hold_reaccept", 32'(mem_busy), 1);
        chk("hold_reaccept_ready", 32'(mem_ready), 0);
        mem_read = 1'b0;
        tick();
        chk("hold2_wait", 32'(mem_ready), 0);
        tick();
        chk("hold2_ready", 32'(mem_ready), 1);
        chk("hold2_data", 32'(mem_data_out), 32'h2020);
        tick();
        chk("hold2_fall", 32'(mem_ready), 0);
        chk("hold2_idle", 32'(mem_busy), 0);
        access("wr3", 1'b0, 1'b1, 16'h0003, 16'h3333, 16'h2020, 1'b0);
        access("wr103", 1'b0, 1'b1, 16'h0103, 16'h5555, 16'h2020, RC);
        access("rd3", 1'b1, 1'b0, 16'h0003, 16'h0000, RC ? 16'h3333 : 16'h5555, 1'b0);
        access("rd103", 1'b1, 1'b0, 16'h0103, 16'h0000, RC ? 16'h0000 : 16'h5555, RC);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
